sa_en_sequencer: RTL and testbench

Parametrised enable sequencer for an N-lane systolic array. It is the successor to the fixed 3-lane, counter-fed enable decoder: it owns its own counter and an FSM with start/done handshake, stall and runtime stream length. Per run it drives one lane-enable bit per array row/column, using an optional weight-preload phase followed by a skewed wavefront. It sits between the array controller and the PE enable inputs.

---
 rtl/sa_pkg.sv | 25 ++
 rtl/sa_en_lane_decode.sv | 43 ++++
 rtl/sa_en_sequencer.sv | 120 ++++++++++++
 tb/tb_sa_en_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sa_pkg : shared state encoding and helpers for the systolic enable sequencer |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
package sa_pkg;

  localparam int SA_N_LANES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_STREAM = 2'b10,
    ST_DONE   = 2'b11
  } sa_state_e;

  function automatic int sa_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_en_lane_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sa_en_lane_decode : per-lane enable decode from phase count, length, state   |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module sa_en_lane_decode
  import sa_pkg::*;
#(
  parameter int N_LANES = SA_N_LANES_DEFAULT,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 5
) (
  input  logic [CNT_W-1:0]   t,
  input  logic [LEN_W-1:0]   k,
  input  logic [1:0]         state,
  input  logic               stall,
  output logic [N_LANES-1:0] en
);

  logic [CNT_W-1:0] k_ext;
  logic             in_load;
  logic             in_stream;

  assign k_ext     = CNT_W'(k);
  assign in_load   = (state == ST_LOAD)   && !stall;
  assign in_stream = (state == ST_STREAM) && !stall;

  // Lane i sees the wavefront for K cycles starting at t == i.
  generate
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      if (i == 0) begin : g_first
        assign en[i] = in_load || (in_stream && (t < k_ext));
      end else begin : g_rest
        localparam logic [CNT_W-1:0] LANE = CNT_W'(i);
        logic [CNT_W-1:0] hi;
        assign hi    = LANE + k_ext;
        assign en[i] = in_load || (in_stream && (t >= LANE) && (t < hi));
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sa_en_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sa_en_sequencer : start/done sequencer driving skewed lane enables           |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module sa_en_sequencer
  import sa_pkg::*;
#(
  parameter int N_LANES = SA_N_LANES_DEFAULT,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               preload,
  input  logic [LEN_W-1:0]   len,
  input  logic               stall,
  output logic               busy,
  output logic               load_en,
  output logic [N_LANES-1:0] en,
  output logic               done
);

  // Wide enough for K+N_LANES-1 without wrap at the largest K.
  localparam int CNT_W = sa_clog2((1 << LEN_W) + N_LANES);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_LANES - 1);
  localparam logic [CNT_W-1:0] SKEW      = CNT_W'(N_LANES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic             preload_q, preload_d;
  logic [CNT_W-1:0] stream_last;
  logic             k_zero;

  assign stream_last = CNT_W'(k_q) + SKEW;
  assign k_zero      = (k_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      preload_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      preload_q <= preload_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    preload_d = preload_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d       = len;
          preload_d = preload;
          cnt_d     = '0;
          if (preload)          state_d = ST_LOAD;
          else if (len == '0)   state_d = ST_DONE;
          else                  state_d = ST_STREAM;
        end
      end
      ST_LOAD: begin
        if (!stall) begin
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = k_zero ? ST_DONE : ST_STREAM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_STREAM: begin
        if (!stall) begin
          if (cnt_q == stream_last) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // LOAD is only reachable with preload latched, so the extra term is redundant by design.
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign load_en = (state_q == ST_LOAD) && preload_q && !stall;

  sa_en_lane_decode #(
    .N_LANES (N_LANES),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) u_decode (
    .t     (cnt_q),
    .k     (k_q),
    .state (state_q),
    .stall (stall),
    .en    (en)
  );

endmodule
`default_nettype wire

// File: tb/tb_sa_en_sequencer.sv
`default_nettype none
// Self-checking bench: a 3-lane and a 16-lane sequencer share stimulus and are
// compared each cycle against a flat slot-position reference model.
module tb_sa_en_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        preload = 1'b0;
  logic [3:0]  len = 4'd0;
  logic        stall = 1'b0;

  logic        busy3, load3, done3;
  logic [2:0]  en3;
  logic        busy16, load16, done16;
  logic [15:0] en16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sa_en_sequencer #(.N_LANES(3), .LEN_W(4)) dut3 (
    .clk(clk), .rst(rst), .start(start), .preload(preload), .len(len),
    .stall(stall), .busy(busy3), .load_en(load3), .en(en3), .done(done3)
  );

  sa_en_sequencer #(.N_LANES(16), .LEN_W(4)) dut16 (
    .clk(clk), .rst(rst), .start(start), .preload(preload), .len(len),
    .stall(stall), .busy(busy16), .load_en(load16), .en(en16), .done(done16)
  );

  // Packed observation: {busy, load_en, done, en[15:0]}
  logic [18:0] obs3, obs16;
  assign obs3  = {busy3, load3, done3, 13'd0, en3};
  assign obs16 = {busy16, load16, done16, en16};

  // Reference model: a run is a flat list of active slots (N load slots if
  // preloading, then K+N-1 stream slots if K>0) followed by one done slot.
  int m_pos[2];
  int m_pre[2];
  int m_k[2];
  int m_total[2];

  function automatic int lanes(input int d);
    return (d == 0) ? 3 : 16;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pos[d] <= -1;
      end else if (m_pos[d] < 0) begin
        if (start) begin
          m_pre[d]   <= preload ? lanes(d) : 0;
          m_k[d]     <= int'(len);
          m_total[d] <= (preload ? lanes(d) : 0) + ((len == 4'd0) ? 0 : int'(len) + lanes(d) - 1);
          m_pos[d]   <= 0;
        end
      end else if (m_pos[d] < m_total[d]) begin
        if (!stall) m_pos[d] <= m_pos[d] + 1;
      end else begin
        m_pos[d] <= -1;
      end
    end
  end

  function automatic logic [18:0] expect_out(input int d);
    logic [18:0] r;
    int t;
    r = '0;
    if (m_pos[d] >= 0) begin
      r[18] = 1'b1;
      if (m_pos[d] == m_total[d]) begin
        r[16] = 1'b1;
      end else if (!stall) begin
        if (m_pos[d] < m_pre[d]) begin
          r[17] = 1'b1;
          for (int i = 0; i < lanes(d); i++) r[i] = 1'b1;
        end else begin
          t = m_pos[d] - m_pre[d];
          for (int i = 0; i < lanes(d); i++) r[i] = (t >= i) && (t < i + m_k[d]);
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input logic s, input logic p, input logic [3:0] l, input logic st);
    @(negedge clk);
    start = s; preload = p; len = l; stall = st;
    #1;
  endtask

  task automatic idle_both();
    int n;
    n = 0;
    drive(0, 0, 0, 0);
    while ((busy3 || busy16) && n < 80) begin
      drive(0, 0, 0, 0);
      n++;
    end
    if (busy3 || busy16) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy3=%0b busy16=%0b required 0 0", busy3, busy16);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({obs3, obs16} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs got3=%h got16=%h required 0", obs3, obs16);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 4'd4, 0);
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, 0, 0);
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL reset_prerun c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
    end
    checks++;
    if (en3 !== 3'b111) begin
      failures++;
      $display("FAIL reset_t2_en got=%b required 111", en3);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (en3 !== 3'b000 || busy3 !== 1'b0 || busy16 !== 1'b0 || done3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async en3=%b busy3=%b busy16=%b done3=%b required 000 0 0 0", en3, busy3, busy16, done3);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0);
      checks++;
      if ({obs3, obs16} !== 38'd0) begin
        failures++;
        $display("FAIL reset_after c=%0d got=%h/%h required idle 0", c, obs3, obs16);
      end
    end
  endtask

  task automatic test_stream_only();
    logic [2:0] seen[$];
    logic [2:0] ref_seq[6];
    int done_at;
    bit ok;
    ref_seq = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};
    done_at = -1;
    idle_both();
    drive(1, 0, 4'd4, 0);
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      drive(0, 0, 0, 0);
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL stream_model c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
      if (done3) done_at = c;
      else if (busy3) seen.push_back(en3);
    end
    checks++;
    if (done_at != 7) begin
      failures++;
      $display("FAIL stream_done_cycle got=%0d required 7", done_at);
    end
    ok = (seen.size() == 6);
    for (int i = 0; i < 6 && ok; i++) if (seen[i] !== ref_seq[i]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stream_en_seq got=%p required %p", seen, ref_seq);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) begin
      failures++;
      $display("FAIL stream_busy_fall busy=%b done=%b required 0 0", busy3, done3);
    end
  endtask

  task automatic test_preload();
    logic [2:0] seen[$];
    logic [2:0] ref_seq[7];
    int done_at, loads;
    bit ok;
    ref_seq = '{3'b111, 3'b111, 3'b111, 3'b001, 3'b011, 3'b110, 3'b100};
    done_at = -1; loads = 0;
    idle_both();
    drive(1, 1, 4'd2, 0);
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      drive(0, 0, 0, 0);
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL preload_model c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
      if (load3) loads++;
      if (done3) done_at = c;
      else if (busy3) seen.push_back(en3);
    end
    ok = (seen.size() == 7);
    for (int i = 0; i < 7 && ok; i++) if (seen[i] !== ref_seq[i]) ok = 0;
    checks++;
    if (!ok || loads != 3 || done_at != 8) begin
      failures++;
      $display("FAIL preload_seq en=%p loads=%0d done_at=%0d required %p 3 8", seen, loads, done_at, ref_seq);
    end
  endtask

  task automatic test_stall();
    logic [2:0] seen[$];
    logic [2:0] ref_seq[8];
    int done_at;
    bit ok;
    ref_seq = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b111, 3'b111, 3'b110, 3'b100};
    done_at = -1;
    idle_both();
    drive(1, 0, 4'd4, 0);
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      drive(0, 0, 0, (c == 3 || c == 4));
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL stall_model c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
      if (done3) done_at = c;
      else if (busy3) seen.push_back(en3);
    end
    ok = (seen.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (seen[i] !== ref_seq[i]) ok = 0;
    checks++;
    if (!ok || done_at != 9) begin
      failures++;
      $display("FAIL stall_seq en=%p done_at=%0d required %p 9", seen, done_at, ref_seq);
    end
  endtask

  task automatic test_edges();
    int act3, act16, d3, d16;
    idle_both();
    drive(1, 0, 4'd0, 0);
    drive(0, 0, 0, 0);
    checks++;
    if (done3 !== 1'b1 || done16 !== 1'b1 || en3 !== 3'b000 || en16 !== 16'd0 || busy3 !== 1'b1) begin
      failures++;
      $display("FAIL len0_done done=%b/%b en=%b/%h busy3=%b required 1/1 0/0 1", done3, done16, en3, en16, busy3);
    end
    idle_both();
    act3 = 0; act16 = 0; d3 = -1; d16 = -1;
    drive(1, 0, 4'd15, 0);
    for (int c = 1; c <= 40 && d16 < 0; c++) begin
      drive(0, 0, 0, 0);
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL len15_model c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
      if (busy3 && !done3 && d3 < 0) act3++;
      if (done3 && d3 < 0) d3 = c;
      if (busy16 && !done16) act16++;
      if (done16) d16 = c;
    end
    checks++;
    if (act16 != 30 || d16 != 31 || act3 != 17 || d3 != 18) begin
      failures++;
      $display("FAIL len15_length n16=%0d@%0d n3=%0d@%0d required 30@31 17@18", act16, d16, act3, d3);
    end
  endtask

  task automatic test_ignored_start();
    int n3, n16, d3;
    n3 = 0; n16 = 0; d3 = -1;
    idle_both();
    drive(1, 0, 4'd4, 0);
    for (int c = 1; c <= 22; c++) begin
      if (c == 3)      drive(1, 1, 4'd9, 0);
      else if (c == 7) drive(1, 0, 4'd2, 0);
      else             drive(0, 0, 0, 0);
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL ignstart_model c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
      if (done3) n3++;
      if (done16) n16++;
    end
    checks++;
    if (n3 != 1 || n16 != 1) begin
      failures++;
      $display("FAIL ignstart_runs done3=%0d done16=%0d required 1 1", n3, n16);
    end
    drive(1, 0, 4'd2, 0);
    for (int c = 1; c <= 10 && d3 < 0; c++) begin
      drive(0, 0, 0, 0);
      if (done3) d3 = c;
    end
    checks++;
    if (d3 != 5) begin
      failures++;
      $display("FAIL ignstart_relaunch done_at=%0d required 5", d3);
    end
  endtask

  task automatic test_random();
    idle_both();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      checks++;
      if ({obs3, obs16} !== {expect_out(0), expect_out(1)}) begin
        failures++;
        $display("FAIL random_model c=%0d got=%h/%h exp=%h/%h", c, obs3, obs16, expect_out(0), expect_out(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream_only();
    test_preload();
    test_stall();
    test_edges();
    test_ignored_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
